rw_txn_responder: RTL
=====================

# rw_txn_responder

Target-side responder for the bench's single-cycle write-pulse / two-cycle read-strobe protocol. Stores write data in a small FIFO. Returns data on each correctly framed read. Counts completed transactions and pulses `done` once both directions reach a programmed count. It sits opposite the stimulus generator, at the far end of the `wr`/`rd` interface, and gives the protocol assertions a real DUT to check against.

## Interface
Parameters:
- `DW`, 8, data width
- `DEPTH`, 8, FIFO entries (power of two, ≥2)
- `TXN_COUNT`, 5, write and read completions required for `done`

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `wr`  in  1  write strobe; push occurs on its rising edge
- `wdata`  in  DW  write data, sampled with `wr` rise
- `rd`  in  1  read strobe; legal frame is exactly 2 cycles high, then low
- `rdata`  out  DW  read data, valid with `rvalid`
- `rvalid`  out  1  one-cycle read-return pulse
- `full`  out  1  FIFO holds DEPTH entries
- `empty`  out  1  FIFO holds 0 entries
- `wr_cnt`  out  8  accepted writes, saturating at 255
- `rd_cnt`  out  8  completed reads, saturating at 255
- `done`  out  1  one-cycle pulse when both counts first reach TXN_COUNT
- `err`  out  1  sticky error flag
- `err_code`  out  2  first error: 0 none, 1 overflow, 2 underflow, 3 read-frame violation

## Operation
- Reset values: `rdata`=0, `rvalid`=0, `full`=0, `empty`=1, `wr_cnt`=0, `rd_cnt`=0, `done`=0, `err`=0, `err_code`=0.
- Reset also clears the FIFO pointers, the `wr` history register, the done-seen flag and the read FSM, which returns to IDLE.
- Write: a push happens when `wr`=1 and the registered previous `wr`=0. `wr` held high for several cycles produces one push.
  - If not full: store `wdata` and increment `wr_cnt`.
  - If full: drop the data, leave `wr_cnt` unchanged, flag overflow.
- Read FSM states: IDLE, R1, R2, WAIT_LOW.
  - IDLE: `rd`=1 → R1.
  - R1: `rd`=1 → R2. `rd`=0 → read-frame violation (short strobe), → IDLE, no pop.
  - R2: `rd`=0 → pop, → IDLE. `rd`=1 → read-frame violation (long strobe), → WAIT_LOW, no pop.
  - WAIT_LOW: `rd`=0 → IDLE.
- Pop: if not empty, return the FIFO head and increment `rd_cnt`. If empty, return `rdata`=0 with `rvalid`=1, leave `rd_cnt` unchanged, flag underflow.
- Simultaneous push and pop: both are evaluated against the occupancy at the start of the cycle.
  - Empty + push + pop: underflow; the data is still stored.
  - Full + push + pop: overflow, the write is dropped; the pop succeeds.
  - Otherwise occupancy is unchanged.
- Pointers wrap modulo DEPTH. Occupancy uses a log2(DEPTH)+1-bit counter.
- `done` fires on the first cycle where `wr_cnt`≥TXN_COUNT and `rd_cnt`≥TXN_COUNT. After that a done-seen flag suppresses further pulses until reset.
- Errors: `err_code` latches only the first error and `err` stays 1 until `rst`. Later errors do not overwrite the code.

## Timing
- Push: with `wr` rise sampled at edge n, `empty` falls and `wr_cnt` increments after edge n. The data is poppable by a pop evaluated at edge n+1 or later.
- Read: with `rd` sampled high at edges k and k+1 and low at k+2, `rvalid`=1 and `rdata` are driven after edge k+2, for exactly one cycle. `rd_cnt` updates on the same edge.
- Minimum read-frame spacing: `rd` can rise again at edge k+3.
- `done` is registered and appears the cycle after the count that satisfies the condition becomes visible.
- `rst` asserted mid-frame or mid-push aborts the operation. Outputs take reset values after the first edge with `rst`=1, and no `rvalid` is emitted for the aborted frame.

## Configuration
- `RW_RESP_ERR_EN` defined: overflow, underflow and read-frame detection drive `err`/`err_code` as above.
- Not defined: `err`=0 and `err_code`=0 permanently and the error registers are not built. Functional behaviour is identical: drops, zero-data underflow returns and FSM transitions (including WAIT_LOW) are unchanged.

## Test plan
- Reset, 5 writes of 0x11..0x55 (1-cycle `wr`, 1–3 idle gaps), then 5 legal 2-cycle reads → `rvalid` ×5 with 0x11..0x55 in order, `rd_cnt`=5, single `done` pulse, `err`=0.
- 9 writes with DEPTH=8 → `full`=1 after the 8th, 9th dropped, `wr_cnt`=8, `err_code`=1; the next 8 reads return the first 8 values.
- Legal read with FIFO empty → `rvalid`=1, `rdata`=0, `rd_cnt`=0, `err_code`=2.
- `rd` high 1 cycle, then `rd` high 3 cycles → no `rvalid` for either, FSM returns to IDLE, `err_code`=3 (first error only), FIFO contents intact.
- Write rise coincident with the pop edge on a 1-entry FIFO → old head returned, new data retained, occupancy stays 1.
- `rst` pulsed between `rd` cycles 1 and 2 after 3 writes → all outputs at reset values, no `rvalid`, `empty`=1; with the macro undefined, repeat the overflow test and check `err`=0.

Source files
------------

// File: rtl/rw_txn_responder.sv
// Target-side responder for the single-cycle wr-pulse / two-cycle rd-strobe protocol.
// Define RW_RESP_ERR_EN to build the sticky overflow/underflow/read-frame error registers.
module rw_txn_responder #(
  parameter int unsigned DW        = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TXN_COUNT = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          full,
  output logic          empty,
  output logic [7:0]    wr_cnt,
  output logic [7:0]    rd_cnt,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [AW:0] DepthC = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StR1, StR2, StWaitLow} rd_st_e;

  rd_st_e          st_q, st_d;
  logic            wr_q;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic [7:0]      wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic            done_q, done_d, seen_q, seen_d;
  logic            push, pop, do_push, do_pop;

  assign full    = (cnt_q == DepthC);
  assign empty   = (cnt_q == '0);
  assign push    = wr & ~wr_q;
  // Push and pop are both judged against the occupancy at the start of the cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    st_d = st_q;
    pop  = 1'b0;
    unique case (st_q)
      StIdle:    if (rd) st_d = StR1;
      StR1:      st_d = rd ? StR2 : StIdle;
      StR2: begin
        if (rd) begin
          st_d = StWaitLow;
        end else begin
          st_d = StIdle;
          pop  = 1'b1;
        end
      end
      StWaitLow: if (!rd) st_d = StIdle;
      default:   st_d = StIdle;
    endcase
  end

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    done_d   = 1'b0;
    seen_d   = seen_q;
    if (do_push) begin
      wptr_d = wptr_q + AW'(1);
      if (wr_cnt_q != 8'hFF) wr_cnt_d = wr_cnt_q + 8'd1;
    end
    if (pop) begin
      rvalid_d = 1'b1;
      rdata_d  = empty ? '0 : mem_q[rptr_q];
    end
    if (do_pop) begin
      rptr_d = rptr_q + AW'(1);
      if (rd_cnt_q != 8'hFF) rd_cnt_d = rd_cnt_q + 8'd1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (!seen_q && ({24'd0, wr_cnt_q} >= TXN_COUNT) && ({24'd0, rd_cnt_q} >= TXN_COUNT)) begin
      done_d = 1'b1;
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= StIdle;
      wr_q     <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wr_cnt_q <= 8'd0;
      rd_cnt_q <= 8'd0;
      done_q   <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      wr_q     <= wr;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      done_q   <= done_d;
      seen_q   <= seen_d;
    end
  end

  // Storage needs no reset; occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
  assign done   = done_q;

`ifdef RW_RESP_ERR_EN
  logic       err_q, err_d, ovf, unf, frame_err;
  logic [1:0] err_code_q, err_code_d;

  assign ovf       = push & full;
  assign unf       = pop & empty;
  assign frame_err = ((st_q == StR1) & ~rd) | ((st_q == StR2) & rd);

  // Overflow can coincide with a frame error; the lower code wins.
  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    if (!err_q && (ovf || unf || frame_err)) begin
      err_d      = 1'b1;
      err_code_d = ovf ? 2'd1 : (unf ? 2'd2 : 2'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign err      = err_q;
  assign err_code = err_code_q;
`else
  assign err      = 1'b0;
  assign err_code = 2'd0;
`endif

endmodule
